// File: rtl/gpio_port.sv
// GPIO port: registered outputs, synchronized inputs with optional per-bit debounce.
// Optional feature macro: GPIO_DEBOUNCE_EN (per-bit debounce counters).

module gpio_in_bit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sync_i,
  output logic stable_o,
  output logic stable_d_o
);
  logic stable_q, stable_d;

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample matching the accepted level restarts the hold count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q + 1'b1;
    if (sync_i == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = sync_i;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end
`else
  // Threshold has no effect without counters.
  if (DEBOUNCE_CYCLES < 1) begin : g_dc_ignored
  end

  assign stable_d = sync_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stable_q <= 1'b0;
    else     stable_q <= stable_d;
  end
`endif

  assign stable_o   = stable_q;
  assign stable_d_o = stable_d;
endmodule

module gpio_port #(
  parameter int IN_WIDTH        = 8,
  parameter int OUT_WIDTH       = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 gpio_wren,
  input  logic [31:0]          bus_wrdata,
  output logic [31:0]          gpio_rddata,
  input  logic [IN_WIDTH-1:0]  gpio_in_pins,
  output logic [OUT_WIDTH-1:0] gpio_out_pins,
  output logic                 in_changed
);
  logic [OUT_WIDTH-1:0] out_q;
  logic [IN_WIDTH-1:0]  sync1_q, sync2_q;
  logic [IN_WIDTH-1:0]  stable, stable_d;
  logic                 chg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      chg_q   <= 1'b0;
    end else begin
      if (gpio_wren) out_q <= bus_wrdata[OUT_WIDTH-1:0];
      sync1_q <= gpio_in_pins;
      sync2_q <= sync1_q;
      chg_q   <= |(stable_d ^ stable);
    end
  end

  for (genvar i = 0; i < IN_WIDTH; i++) begin : g_in
    gpio_in_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
      .clk       (clk),
      .rst       (rst),
      .sync_i    (sync2_q[i]),
      .stable_o  (stable[i]),
      .stable_d_o(stable_d[i])
    );
  end

  if (OUT_WIDTH < 32) begin : g_wr_unused
    logic unused_wrdata;
    assign unused_wrdata = ^bus_wrdata[31:OUT_WIDTH];
  end

  always_comb begin
    gpio_rddata                = '0;
    gpio_rddata[IN_WIDTH-1:0]  = stable;
  end

  assign gpio_out_pins = out_q;
  assign in_changed    = chg_q;
endmodule

// File: tb/tb_gpio_port.sv
// Directed scoreboard bench for gpio_port; expectations are queued as stimulus is driven.
module tb_gpio_port;
  localparam int DC = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int EFF_DC = DC;
`else
  localparam int EFF_DC = 1;
`endif
  localparam int LAT = EFF_DC + 2;

  logic        clk, rst, gpio_wren, in_changed;
  logic [31:0] bus_wrdata, gpio_rddata;
  logic [7:0]  gpio_in_pins, gpio_out_pins;

  gpio_port #(.IN_WIDTH(8), .OUT_WIDTH(8), .DEBOUNCE_CYCLES(DC)) dut (
    .clk          (clk),
    .rst          (rst),
    .gpio_wren    (gpio_wren),
    .bus_wrdata   (bus_wrdata),
    .gpio_rddata  (gpio_rddata),
    .gpio_in_pins (gpio_in_pins),
    .gpio_out_pins(gpio_out_pins),
    .in_changed   (in_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic [7:0]  op;
    logic        ch;
  } exp_t;

  exp_t       sbq[$];
  int         nvec  = 0;
  int         nfail = 0;
  logic [7:0] exp_out;

  task automatic push(input string tag, input logic [31:0] rd, input logic [7:0] op, input logic ch);
    exp_t e;
    e.tag = tag; e.rd = rd; e.op = op; e.ch = ch;
    sbq.push_back(e);
  endtask

  task automatic compare_pop();
    exp_t e;
    if (sbq.size() == 0) begin
      nfail++;
      $error("FAIL sb_empty got 0 entries want 1");
      return;
    end
    e = sbq.pop_front();
    nvec++;
    assert (gpio_rddata === e.rd) else begin
      nfail++;
      $error("FAIL %s rddata got %h want %h", e.tag, gpio_rddata, e.rd);
    end
    assert (gpio_out_pins === e.op) else begin
      nfail++;
      $error("FAIL %s out_pins got %h want %h", e.tag, gpio_out_pins, e.op);
    end
    assert (in_changed === e.ch) else begin
      nfail++;
      $error("FAIL %s in_changed got %b want %b", e.tag, in_changed, e.ch);
    end
  endtask

  task automatic tick_check();
    @(posedge clk);
    #1;
    compare_pop();
  endtask

  task automatic wr_step(input string tag, input logic [31:0] d, input logic [31:0] rd);
    gpio_wren  = 1'b1;
    bus_wrdata = d;
    exp_out    = d[7:0];
    push(tag, rd, exp_out, 1'b0);
    tick_check();
    gpio_wren  = 1'b0;
  endtask

  // Drive val for W edges then base; an accepted level shows from edge LAT, and
  // its removal shows LAT edges after the pins fall back.
  task automatic pulse(input string tag, input logic [7:0] val, input logic [7:0] base,
                       input int w, input int n, input int wr_idx, input logic [31:0] wr_data);
    logic acc, ch;
    logic [7:0] rdv;
    acc = (w >= EFF_DC) && (val != base);
    for (int i = 1; i <= n; i++) begin
      gpio_in_pins = (i <= w) ? val : base;
      if (i == wr_idx) begin
        gpio_wren  = 1'b1;
        bus_wrdata = wr_data;
        exp_out    = wr_data[7:0];
      end
      rdv = (acc && i >= LAT && i < LAT + w) ? val : base;
      ch  = acc && (i == LAT || i == LAT + w);
      push(tag, {24'h0, rdv}, exp_out, ch);
      tick_check();
      gpio_wren = 1'b0;
    end
  endtask

  initial begin
    rst          = 1'b1;
    gpio_wren    = 1'b0;
    bus_wrdata   = '0;
    gpio_in_pins = '0;
    exp_out      = '0;
    #12;
    push("reset", 32'h0, 8'h00, 1'b0);
    compare_pop();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    repeat (2) begin
      push("idle", 32'h0, 8'h00, 1'b0);
      tick_check();
    end

    wr_step("write", 32'hDEADBE5A, 32'h0);
    repeat (10) begin
      push("hold", 32'h0, exp_out, 1'b0);
      tick_check();
    end
    wr_step("b2b_1", 32'h00000011, 32'h0);
    wr_step("b2b_2", 32'hFFFFFF22, 32'h0);

    pulse("accept81", 8'h81, 8'h00, 100, LAT + 3, 0, 32'h0);
    pulse("drop81",   8'h00, 8'h81, 100, LAT + 3, 0, 32'h0);
`ifdef GPIO_DEBOUNCE_EN
    pulse("glitch_rej", 8'h08, 8'h00, DC - 1, 12, 0, 32'h0);
`else
    pulse("glitch_pass", 8'h08, 8'h00, 1, 8, 0, 32'h0);
`endif
    pulse("pulse_acc", 8'h08, 8'h00, EFF_DC, EFF_DC + LAT + 3, 0, 32'h0);
    pulse("simul", 8'hFF, 8'h00, 100, LAT + 3, LAT, 32'h0000003C);

    wr_step("write_a5", 32'h000000A5, 32'hFF);
    pulse("rst_pre", 8'h00, 8'hFF, 100, 2, 0, 32'h0);
    #3;
    rst = 1'b1;
    #1;
    exp_out = 8'h00;
    push("rst_async", 32'h0, 8'h00, 1'b0);
    compare_pop();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    pulse("post_rst", 8'h00, 8'h00, 100, 8, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
